spi_exe_master: RTL and testbench

SPI_EXE_MASTER -- requirements
Module: spi_exe_master

---
 rtl/spi_exe_master.sv | 218 +++++++++++++++++++++
 tb/tb_spi_exe_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_exe_master.sv
// SPI mode-0 master for an external execute unit: ships {argA, argB, oper} MSB-first,
// idles for a short gap, then reads back an 8-bit result and {PF,ZF,SF,OF} flags.
module spi_exe_master #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 2
) (
  input  logic       i_clk_p,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  input  logic [7:0] i_oper,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_RECV  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (GAP_BITS > 24) ? $clog2(GAP_BITS + 1) : 5;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH  = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] SEND_LAST = BIT_W'(23);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(GAP_BITS - 1);
  localparam logic [BIT_W-1:0] RECV_LAST = BIT_W'(11);

  state_t           state_r, state_nxt_s;
  logic [DIV_W-1:0] div_cnt_r, div_nxt_s, div_step_s;
  logic [BIT_W-1:0] bit_cnt_r, bit_nxt_s;
  logic [23:0]      tx_sr_r, tx_nxt_s;
  logic [11:0]      rx_sr_r, rx_nxt_s;
  logic [7:0]       result_r, result_nxt_s;
  logic [3:0]       flags_r, flags_nxt_s;
  logic             sclk_r, sclk_nxt_s, mosi_r, mosi_nxt_s, cs_r, cs_nxt_s;
  logic             busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic             period_end_s, rise_s, sclk_step_s;

  // Divider phase: low half first, high half second, wrapping at the period end
  assign period_end_s = (div_cnt_r == DIV_LAST);
  assign rise_s       = (div_cnt_r == DIV_RISE);
  assign div_step_s   = period_end_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
  assign sclk_step_s  = (div_step_s >= DIV_HIGH);

  // State register
  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_nxt_s = ST_SEND;
        else         state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (period_end_s && (bit_cnt_r == SEND_LAST))
          state_nxt_s = (GAP_BITS == 0) ? ST_RECV : ST_GAP;
        else
          state_nxt_s = ST_SEND;
      end
      ST_GAP: begin
        if (period_end_s && (bit_cnt_r == GAP_LAST)) state_nxt_s = ST_RECV;
        else                                         state_nxt_s = ST_GAP;
      end
      ST_RECV: begin
        if (period_end_s && (bit_cnt_r == RECV_LAST)) state_nxt_s = ST_GUARD;
        else                                          state_nxt_s = ST_RECV;
      end
      ST_GUARD: begin
        if (period_end_s) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_GUARD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values for counters, shift registers and the registered outputs
  always_comb begin
    div_nxt_s    = {DIV_W{1'b0}};
    bit_nxt_s    = bit_cnt_r;
    tx_nxt_s     = tx_sr_r;
    rx_nxt_s     = rx_sr_r;
    result_nxt_s = result_r;
    flags_nxt_s  = flags_r;
    sclk_nxt_s   = 1'b0;
    mosi_nxt_s   = 1'b0;
    cs_nxt_s     = 1'b1;
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bit_nxt_s = {BIT_W{1'b0}};
        if (i_start) begin
          tx_nxt_s   = {i_argA, i_argB, i_oper};
          rx_nxt_s   = 12'h000;
          mosi_nxt_s = i_argA[7];
          cs_nxt_s   = 1'b0;
          busy_nxt_s = 1'b1;
        end else begin
          tx_nxt_s   = tx_sr_r;
        end
      end
      ST_SEND: begin
        cs_nxt_s   = 1'b0;
        busy_nxt_s = 1'b1;
        div_nxt_s  = div_step_s;
        sclk_nxt_s = sclk_step_s;
        // Data advances on the falling edge so the responder sees it stable on the rise
        if (period_end_s && (bit_cnt_r == SEND_LAST)) begin
          bit_nxt_s  = {BIT_W{1'b0}};
          tx_nxt_s   = 24'h000000;
          mosi_nxt_s = 1'b0;
        end else if (period_end_s) begin
          bit_nxt_s  = bit_cnt_r + BIT_W'(1);
          tx_nxt_s   = {tx_sr_r[22:0], 1'b0};
          mosi_nxt_s = tx_sr_r[22];
        end else begin
          mosi_nxt_s = tx_sr_r[23];
        end
      end
      ST_GAP: begin
        cs_nxt_s   = 1'b0;
        busy_nxt_s = 1'b1;
        div_nxt_s  = div_step_s;
        sclk_nxt_s = sclk_step_s;
        if (period_end_s && (bit_cnt_r == GAP_LAST)) bit_nxt_s = {BIT_W{1'b0}};
        else if (period_end_s)                       bit_nxt_s = bit_cnt_r + BIT_W'(1);
        else                                         bit_nxt_s = bit_cnt_r;
      end
      ST_RECV: begin
        cs_nxt_s   = 1'b0;
        busy_nxt_s = 1'b1;
        div_nxt_s  = div_step_s;
        sclk_nxt_s = sclk_step_s;
        if (rise_s) rx_nxt_s = {rx_sr_r[10:0], i_miso};
        else        rx_nxt_s = rx_sr_r;
        // Results publish only once the whole 12-bit word is in
        if (period_end_s && (bit_cnt_r == RECV_LAST)) begin
          bit_nxt_s    = {BIT_W{1'b0}};
          cs_nxt_s     = 1'b1;
          result_nxt_s = rx_sr_r[11:4];
          flags_nxt_s  = rx_sr_r[3:0];
          done_nxt_s   = 1'b1;
        end else if (period_end_s) begin
          bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end else begin
          bit_nxt_s = bit_cnt_r;
        end
      end
      ST_GUARD: begin
        div_nxt_s = div_step_s;
        if (period_end_s) busy_nxt_s = 1'b0;
        else              busy_nxt_s = 1'b1;
      end
      default: begin
        bit_nxt_s = {BIT_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      tx_sr_r   <= 24'h000000;
      rx_sr_r   <= 12'h000;
      result_r  <= 8'h00;
      flags_r   <= 4'h0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      bit_cnt_r <= bit_nxt_s;
      tx_sr_r   <= tx_nxt_s;
      rx_sr_r   <= rx_nxt_s;
      result_r  <= result_nxt_s;
      flags_r   <= flags_nxt_s;
      sclk_r    <= sclk_nxt_s;
      mosi_r    <= mosi_nxt_s;
      cs_r      <= cs_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign o_sclk   = sclk_r;
  assign o_mosi   = mosi_r;
  assign o_cs     = cs_r;
  assign o_result = result_r;
  assign o_flags  = flags_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule

// File: tb/tb_spi_exe_master.sv
// Directed bench for spi_exe_master: a default-parameter instance and a
// CLK_DIV=1 / GAP_BITS=0 instance, each with a bench-side SPI responder.
module tb_spi_exe_master;

  typedef struct {
    int          d;
    logic [7:0]  a, b, op;
    logic [11:0] resp;
    bit          hold;
    logic [23:0] e_mosi;
    logic [7:0]  e_res;
    logic [3:0]  e_flg;
    int          e_done;
    int          e_edges;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      start_r = 2'b00;
  logic [7:0]      arg_a = 8'h00, arg_b = 8'h00, arg_op = 8'h00;
  logic [1:0]      miso_r = 2'b00;
  logic [1:0]      sclk_s, mosi_s, cs_s, busy_s, done_s;
  logic [1:0][7:0] res_s;
  logic [1:0][3:0] flg_s;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] resp_cfg [2] = '{12'h000, 12'h000};
  bit          hold_cfg [2] = '{1'b0, 1'b0};
  int          gap_cfg  [2] = '{2, 0};
  int          rise_cnt [2] = '{0, 0};
  int          hi_edges [2] = '{0, 0};
  int          mosi_bad [2] = '{0, 0};
  int          cs_run   [2] = '{0, 0};
  int          cs_run_last [2] = '{0, 0};
  logic [23:0] cap      [2] = '{24'h0, 24'h0};
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  int          mon_j;

  always #5 clk = ~clk;

  spi_exe_master #(.CLK_DIV(2), .GAP_BITS(2)) u_dut0 (
    .i_clk_p(clk), .i_rst(rst), .i_start(start_r[0]),
    .i_argA(arg_a), .i_argB(arg_b), .i_oper(arg_op),
    .o_sclk(sclk_s[0]), .o_mosi(mosi_s[0]), .i_miso(miso_r[0]), .o_cs(cs_s[0]),
    .o_result(res_s[0]), .o_flags(flg_s[0]), .o_busy(busy_s[0]), .o_done(done_s[0])
  );

  spi_exe_master #(.CLK_DIV(1), .GAP_BITS(0)) u_dut1 (
    .i_clk_p(clk), .i_rst(rst), .i_start(start_r[1]),
    .i_argA(arg_a), .i_argB(arg_b), .i_oper(arg_op),
    .o_sclk(sclk_s[1]), .o_mosi(mosi_s[1]), .i_miso(miso_r[1]), .o_cs(cs_s[1]),
    .o_result(res_s[1]), .o_flags(flg_s[1]), .o_busy(busy_s[1]), .o_done(done_s[1])
  );

  // Responder and bus monitor: outputs only change on posedge, so negedge sampling sees every edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prev_cs[d] && !cs_s[d]) begin
        rise_cnt[d]    = 0;
        cap[d]         = 24'h0;
        mosi_bad[d]    = 0;
        cs_run_last[d] = cs_run[d];
        cs_run[d]      = 0;
        miso_r[d]      = hold_cfg[d];
      end
      if (cs_s[d] === 1'b1) cs_run[d]++;
      if (!prev_sclk[d] && sclk_s[d]) begin
        if (cs_s[d]) hi_edges[d]++;
        else begin
          if (rise_cnt[d] < 24) cap[d] = {cap[d][22:0], mosi_s[d]};
          else if (mosi_s[d] !== 1'b0) mosi_bad[d]++;
          rise_cnt[d]++;
        end
      end
      if (prev_sclk[d] && !sclk_s[d]) begin
        mon_j = rise_cnt[d] - 24 - gap_cfg[d];
        if (hold_cfg[d])                 miso_r[d] = 1'b1;
        else if (mon_j >= 0 && mon_j < 12) miso_r[d] = resp_cfg[d][11 - mon_j];
        else                             miso_r[d] = 1'b0;
      end
      prev_cs[d]   = cs_s[d];
      prev_sclk[d] = sclk_s[d];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One transaction; clock 0 is the cycle with i_start high
  task automatic run_frame(input int d, input logic [7:0] a, b, op, input logic [11:0] resp,
                           input bit hold, input bit again, output int done_at,
                           output int ndone, output int busy_low_at, output int chg);
    logic [11:0] prev;
    int cnt;
    resp_cfg[d] = resp;
    hold_cfg[d] = hold;
    arg_a = a; arg_b = b; arg_op = op;
    prev = {res_s[d], flg_s[d]};
    start_r[d] = 1'b1;
    cnt = 0; done_at = -1; ndone = 0; busy_low_at = -1; chg = 0;
    while (cnt < 400 && busy_low_at < 0) begin
      tick();
      cnt++;
      start_r[d] = again && (cnt == 10 || cnt == 152);
      if (done_s[d]) begin
        ndone++;
        if (done_at < 0) done_at = cnt;
      end else if (done_at < 0 && {res_s[d], flg_s[d]} !== prev) begin
        chg++;
      end
      if (cnt > 1 && !busy_s[d]) busy_low_at = cnt;
    end
    start_r[d] = 1'b0;
  endtask

  vec_t vecs [5];
  vec_t v;
  int   done_at, nd, bl, chg, cnt;

  initial begin
    vecs[0] = '{0, 8'h05, 8'h03, 8'h10, 12'h084, 1'b0, 24'h050310, 8'h08, 4'h4, 153, 38};
    vecs[1] = '{0, 8'hA5, 8'h3C, 8'hF0, 12'hC3A, 1'b0, 24'hA53CF0, 8'hC3, 4'hA, 153, 38};
    vecs[2] = '{0, 8'h12, 8'h34, 8'h56, 12'h000, 1'b1, 24'h123456, 8'hFF, 4'hF, 153, 38};
    vecs[3] = '{1, 8'hFF, 8'h01, 8'h00, 12'h005, 1'b0, 24'hFF0100, 8'h00, 4'h5, 73, 36};
    vecs[4] = '{1, 8'h80, 8'h00, 8'h01, 12'h7E8, 1'b0, 24'h800001, 8'h7E, 4'h8, 73, 36};

    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_cs", d), 32'(cs_s[d]), 32'd1);
      chk($sformatf("rst%0d_sclk", d), 32'(sclk_s[d]), 32'd0);
      chk($sformatf("rst%0d_mosi", d), 32'(mosi_s[d]), 32'd0);
      chk($sformatf("rst%0d_busy", d), 32'(busy_s[d]), 32'd0);
      chk($sformatf("rst%0d_done", d), 32'(done_s[d]), 32'd0);
      chk($sformatf("rst%0d_res", d), 32'(res_s[d]), 32'h00);
      chk($sformatf("rst%0d_flg", d), 32'(flg_s[d]), 32'h0);
    end
    rst = 1'b0;
    tick();

    // Reset in the middle of SEND aborts the frame
    resp_cfg[0] = 12'h084; hold_cfg[0] = 1'b0;
    arg_a = 8'h05; arg_b = 8'h03; arg_op = 8'h10;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    cnt = 0;
    while (rise_cnt[0] < 10 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("abort_reach10", 32'(rise_cnt[0]), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cs", 32'(cs_s[0]), 32'd1);
    chk("abort_sclk", 32'(sclk_s[0]), 32'd0);
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    nd = 0;
    repeat (200) begin
      tick();
      if (done_s[0]) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_res", 32'(res_s[0]), 32'h00);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      run_frame(v.d, v.a, v.b, v.op, v.resp, v.hold, 1'b0, done_at, nd, bl, chg);
      chk($sformatf("v%0d_res", i), 32'(res_s[v.d]), 32'(v.e_res));
      chk($sformatf("v%0d_flg", i), 32'(flg_s[v.d]), 32'(v.e_flg));
      chk($sformatf("v%0d_mosi", i), 32'(cap[v.d]), 32'(v.e_mosi));
      chk($sformatf("v%0d_done_clk", i), 32'(done_at), 32'(v.e_done));
      chk($sformatf("v%0d_edges", i), 32'(rise_cnt[v.d]), 32'(v.e_edges));
      chk($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
      chk($sformatf("v%0d_mosi_zero", i), 32'(mosi_bad[v.d]), 32'd0);
      chk($sformatf("v%0d_cs_hi_edges", i), 32'(hi_edges[v.d]), 32'd0);
      chk($sformatf("v%0d_no_partial", i), 32'(chg), 32'd0);
      tick(); tick();
    end

    // Extra start pulses inside a running frame are ignored
    run_frame(0, 8'h05, 8'h03, 8'h10, 12'h084, 1'b0, 1'b1, done_at, nd, bl, chg);
    chk("restart_ndone", 32'(nd), 32'd1);
    chk("restart_done_clk", 32'(done_at), 32'd153);
    chk("restart_busy_low", 32'(bl - done_at), 32'd4);
    chk("restart_res", 32'({res_s[0], flg_s[0]}), 32'h084);
    tick(); tick();

    // Back-to-back: start on the first IDLE cycle after GUARD
    run_frame(0, 8'h11, 8'h22, 8'h33, 12'h5A3, 1'b0, 1'b0, done_at, nd, bl, chg);
    chk("b2b_first_res", 32'({res_s[0], flg_s[0]}), 32'h5A3);
    run_frame(0, 8'h44, 8'h55, 8'h66, 12'h3C6, 1'b0, 1'b0, done_at, nd, bl, chg);
    chk("b2b_cs_gap", 32'(cs_run_last[0]), 32'd5);
    chk("b2b_done_clk", 32'(done_at), 32'd153);
    chk("b2b_second_res", 32'({res_s[0], flg_s[0]}), 32'h3C6);
    chk("b2b_mosi", 32'(cap[0]), 32'h445566);

    // Start coincident with reset is ignored
    tick();
    rst = 1'b1;
    start_r[0] = 1'b1;
    tick();
    rst = 1'b0;
    start_r[0] = 1'b0;
    chk("rst_start_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_start_cs", 32'(cs_s[0]), 32'd1);
    tick(); tick(); tick();
    chk("rst_start_busy_later", 32'(busy_s[0]), 32'd0);
    chk("rst_start_res", 32'(res_s[0]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
